misao_mem_arbiter: RTL
======================

Name: misao_mem_arbiter

Overview:
- Two-requester arbiter sharing the single 8-bit MISA-O memory port between the core (port A) and an auxiliary master (port B: program loader or debug). Port B does not drive the bus until granted.
- Round-robin with a bounded burst hold per owner.
- Pipelined single-beat transfers: one access per cycle, registered memory command, read data returned to the issuing requester.

Parameters:
- ADDR_W, 15, address width (matches mem_addr).
- DATA_W, 8, data width.
- MAX_BURST, 4, max consecutive accepted transfers by one owner while the other requests; legal range 1..15.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  port A request valid.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- mem_enable_read  out  1  memory read strobe.
- mem_enable_write  out  1  memory write strobe.
- mem_rw  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_data_out  out  DATA_W  memory write data.
- mem_data_in  in  DATA_W  memory read data, combinational from mem_addr.

Behaviour:
- Handshake: transfer occurs on a posedge where x_req & x_gnt. x_gnt is combinational from registered state and the current a_req/b_req only; it never depends on addr/we/wdata. Requester holds req/we/addr/wdata stable until accepted.
- Arbitration state:
  - owner (A/B): reset value B, so A wins the first contest.
  - burst_cnt (4 bits): reset value 0.
- Grant rule, at most one grant per cycle:
  - Only one port requests: grant it.
  - Both request and owner's burst_cnt < MAX_BURST-1: grant owner.
  - Both request and burst_cnt reached MAX_BURST-1: grant the non-owner.
  - Neither requests: no grant, state unchanged.
- On acceptance:
  - Winner differs from owner: owner <= winner, burst_cnt <= 0.
  - Same owner: burst_cnt <= burst_cnt+1, saturating at MAX_BURST-1.
  - With MAX_BURST=1 both ports alternate strictly under contention.
- Memory command, registered: for a transfer accepted at posedge t, the command is driven during cycle t+1.
  - mem_addr = addr, mem_rw = we, mem_data_out = wdata.
  - mem_enable_write = we, mem_enable_read = ~we.
  - Idle cycles: both enables 0, mem_rw 0; mem_addr and mem_data_out hold their last value.
- Read return: at the posedge ending cycle t+1, mem_data_in is captured into x_rdata of the issuing port (registered tag). x_rvalid is high for exactly one cycle, t+2. The other port's rdata is unchanged.
- Latency: read accept to rvalid = 2 cycles. Throughput: 1 transfer per cycle, back-to-back, including A/B interleaved.
- Writes produce no rvalid.
- Read-after-write to the same address on consecutive accepts returns the new data, because memory writes at the end of t+1.
- Reset, asynchronous, takes effect immediately including mid-burst:
  - All outputs 0: gnt is 0 while rst is high.
  - owner = B, burst_cnt = 0.
  - Any in-flight command or pending rvalid is dropped.
- Simultaneous same-cycle first requests after reset: A wins.

Optional Feature:
- MISAO_ARB_STATS_EN defined adds:
  - ports stat_clr (in, 1), stat_a_cnt (out, 16) and stat_b_cnt (out, 16).
  - Each counter increments on every accepted transfer of its port and saturates at 16'hFFFF.
  - stat_clr zeroes both counters synchronously; clear wins over a same-cycle increment.
  - Reset value 0.
- MISAO_ARB_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- A-only read: mem[0x03]=0x5A, a_req read addr 3 → a_gnt same cycle; mem_enable_read=1, mem_addr=3 next cycle; a_rvalid=1, a_rdata=0x5A two cycles after accept; b_rvalid stays 0.
- Contention, MAX_BURST=4: a_req and b_req held continuously from reset → grant sequence A,A,A,A,B,B,B,B,A…; exactly one gnt per cycle, no idle cycles on mem.
- B write then A read of the same address: B writes 0xC3 to 0x10, next cycle A reads 0x10 → mem_enable_write pulse with data 0xC3, then a_rdata=0xC3 at a_rvalid.
- Owner drops mid-burst: A owns with burst_cnt=1 and drops req while B requests → B granted the next cycle, burst_cnt resets; A re-requests → A waits until B reaches its burst limit or drops.
- Reset mid-transfer: assert rst in the cycle after a read accept → all outputs 0 immediately and no rvalid after release; first contested request after release goes to A.
- With MISAO_ARB_STATS_EN: 5 A transfers and 3 B transfers → stat_a_cnt=5, stat_b_cnt=3; stat_clr pulse → both 0; 65536 A transfers → stat_a_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/misao_mem_arbiter_if.sv
// Requester and memory-side signals of the MISA-O memory arbiter.
// slave: the arbiter's view; master: the requesters and the memory.
interface misao_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) ();
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_enable_read;
  logic              mem_enable_write;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_enable_read, mem_enable_write, mem_rw, mem_addr, mem_data_out,
    input  mem_data_in
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_enable_read, mem_enable_write, mem_rw, mem_addr, mem_data_out,
    output mem_data_in
  );
endinterface

// File: rtl/misao_mem_arbiter.sv
// Round-robin arbiter with bounded bursts sharing the MISA-O memory port between core (A) and loader/debug (B).
// Define MISAO_ARB_STATS_EN to add per-port accepted-transfer counters (stat_clr, stat_a_cnt, stat_b_cnt).
module misao_mem_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MISAO_ARB_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_a_cnt,
  output logic [15:0] stat_b_cnt,
`endif
  misao_mem_arbiter_if.slave bus
);

  localparam logic [0:0] OWN_A      = 1'b0;
  localparam logic [0:0] OWN_B      = 1'b1;
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [0:0]        owner;
  logic              owner_vld;
  logic [3:0]        burst_cnt;
  logic              both_req;
  logic              burst_done;
  logic [0:0]        win;
  logic              a_gnt_c;
  logic              b_gnt_c;
  logic              acc;

  logic              cmd_vld_p0;
  logic              cmd_we_p0;
  logic [0:0]        cmd_tag_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              a_rvalid_p1;
  logic              b_rvalid_p1;
  logic [DATA_W-1:0] a_rdata_p1;
  logic [DATA_W-1:0] b_rdata_p1;

  function automatic logic [3:0] burst_inc(input logic [3:0] c);
    return (c >= BURST_LAST) ? BURST_LAST : c + 4'd1;
  endfunction

  // Out of reset B is owner but holds no burst, so a contested first cycle yields to A.
  always_comb begin
    both_req   = bus.a_req & bus.b_req;
    burst_done = ~owner_vld | (burst_cnt >= BURST_LAST);
    if (both_req)
      win = burst_done ? ~owner : owner;
    else
      win = bus.b_req ? OWN_B : OWN_A;
    a_gnt_c = ~rst & bus.a_req & (win == OWN_A);
    b_gnt_c = ~rst & bus.b_req & (win == OWN_B);
    acc     = a_gnt_c | b_gnt_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_B;
      owner_vld <= 1'b0;
      burst_cnt <= 4'd0;
    end else if (acc) begin
      owner_vld <= 1'b1;
      if ((win != owner) || !owner_vld) begin
        owner     <= win;
        burst_cnt <= 4'd0;
      end else begin
        burst_cnt <= burst_inc(burst_cnt);
      end
    end
  end

  // Stage p0: registered memory command for the transfer accepted last edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_vld_p0 <= 1'b0;
      cmd_we_p0  <= 1'b0;
      cmd_tag_p0 <= OWN_A;
      addr_p0    <= '0;
      wdata_p0   <= '0;
    end else begin
      cmd_vld_p0 <= acc;
      if (acc) begin
        cmd_tag_p0 <= win;
        cmd_we_p0  <= (win == OWN_B) ? bus.b_we    : bus.a_we;
        addr_p0    <= (win == OWN_B) ? bus.b_addr  : bus.a_addr;
        wdata_p0   <= (win == OWN_B) ? bus.b_wdata : bus.a_wdata;
      end
    end
  end

  // Stage p1: read data captured into the issuing port, valid for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid_p1 <= 1'b0;
      b_rvalid_p1 <= 1'b0;
      a_rdata_p1  <= '0;
      b_rdata_p1  <= '0;
    end else begin
      a_rvalid_p1 <= cmd_vld_p0 & ~cmd_we_p0 & (cmd_tag_p0 == OWN_A);
      b_rvalid_p1 <= cmd_vld_p0 & ~cmd_we_p0 & (cmd_tag_p0 == OWN_B);
      if (cmd_vld_p0 && !cmd_we_p0 && (cmd_tag_p0 == OWN_A))
        a_rdata_p1 <= bus.mem_data_in;
      if (cmd_vld_p0 && !cmd_we_p0 && (cmd_tag_p0 == OWN_B))
        b_rdata_p1 <= bus.mem_data_in;
    end
  end

  assign bus.a_gnt            = a_gnt_c;
  assign bus.b_gnt            = b_gnt_c;
  assign bus.a_rvalid         = a_rvalid_p1;
  assign bus.b_rvalid         = b_rvalid_p1;
  assign bus.a_rdata          = a_rdata_p1;
  assign bus.b_rdata          = b_rdata_p1;
  assign bus.mem_enable_read  = cmd_vld_p0 & ~cmd_we_p0;
  assign bus.mem_enable_write = cmd_vld_p0 & cmd_we_p0;
  assign bus.mem_rw           = cmd_vld_p0 & cmd_we_p0;
  assign bus.mem_addr         = addr_p0;
  assign bus.mem_data_out     = wdata_p0;

`ifdef MISAO_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_a_cnt <= 16'd0;
      stat_b_cnt <= 16'd0;
    end else if (stat_clr) begin
      stat_a_cnt <= 16'd0;
      stat_b_cnt <= 16'd0;
    end else begin
      if (a_gnt_c) stat_a_cnt <= sat_inc16(stat_a_cnt);
      if (b_gnt_c) stat_b_cnt <= sat_inc16(stat_b_cnt);
    end
  end
`endif

endmodule
